// File: rtl/apb_master_bridge.sv
// apb_master_bridge: core memory-stage data port to APB master.
// Decodes addr[31:12] against BASE and addr[11:8] as the slave slot. It runs
// the APB SETUP/ACCESS sequence and returns a one-cycle ready pulse with the
// read data or an error.
// Optional feature: define APB_TIMEOUT_EN to bound ACCESS wait states by
// TIMEOUT_CYC. When it times out, the bridge finishes with err=1.
module apb_master_bridge #(
  parameter int          NUM_SLV     = 4,
  parameter logic [19:0] BASE        = 20'h10000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic                    write,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic                    ready,
  output logic [31:0]             rdata,
  output logic                    err,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic                    PENABLE,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [NUM_SLV*32-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY
);

  // Reject out-of-range configurations when the design is elaborated.
  if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
    $error("apb_master_bridge: NUM_SLV must be 1..16");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYC must be 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  off_q, off_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

`ifdef APB_TIMEOUT_EN
  // The counter value on the last allowed ACCESS cycle without PREADY.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic        addr_ok;
  logic [31:0] sel_rdata;
  logic        sel_ready;

  assign addr_ok = (addr[31:12] == BASE) && ({28'd0, addr[11:8]} < 32'(NUM_SLV));

  // Mux the captured slave's PRDATA/PREADY. All other slaves are ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == 4'(i)) begin
        sel_rdata = PRDATA[i*32 +: 32];
        sel_ready = PREADY[i];
      end
    end
  end

  // State and captured-transfer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef APB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next state. ready is a pulse, while rdata/err hold until the next completion.
  // req is ignored while ready is high, so a core that holds req through its
  // ready cycle does not launch a duplicate transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    write_d = write_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef APB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req && !ready_q) begin
          if (addr_ok) begin
            idx_d   = addr[11:8];
            off_d   = addr[7:0];
            write_d = write;
            wdata_d = wdata;
            state_d = S_SETUP;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        // PREADY takes priority over a timeout on the same edge.
        if (sel_ready) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = write_q ? 32'd0 : sel_rdata;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // APB strobes are decoded from the state, so an async reset drops them at once.
  always_comb begin
    PSEL    = '0;
    PENABLE = 1'b0;
    if (state_q == S_SETUP || state_q == S_ACCESS) begin
      for (int i = 0; i < NUM_SLV; i++) PSEL[i] = (idx_q == 4'(i));
      PENABLE = (state_q == S_ACCESS);
    end
  end

  assign PADDR  = {24'h0, off_q};
  assign PWRITE = write_q;
  assign PWDATA = wdata_q;
  assign ready  = ready_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (NUM_SLV=4, TIMEOUT_CYC=4).
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge. Cycle k is the k-th falling edge after the request is presented.
module tb_apb_master_bridge;
  localparam int NS = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           req = 1'b0;
  logic           write = 1'b0;
  logic [31:0]    addr = '0;
  logic [31:0]    wdata = '0;
  logic           ready;
  logic [31:0]    rdata;
  logic           err;
  logic [31:0]    PADDR;
  logic           PWRITE;
  logic [31:0]    PWDATA;
  logic           PENABLE;
  logic [NS-1:0]  PSEL;
  logic [NS*32-1:0] PRDATA = '0;
  logic [NS-1:0]  PREADY = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(.NUM_SLV(NS), .BASE(20'h10000), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .write(write), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .err(err), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request. The following rising edge is edge 0.
  task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; write = w; addr = a; wdata = d;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    checks++; if (PSEL !== 4'b0000) begin errors++; $display("FAIL rst_psel got=%b exp=0000", PSEL); end
    checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL rst_penable got=%b exp=0", PENABLE); end
    checks++; if (PWRITE !== 1'b0) begin errors++; $display("FAIL rst_pwrite got=%b exp=0", PWRITE); end
    checks++; if (PADDR !== 32'h0) begin errors++; $display("FAIL rst_paddr got=%h exp=0", PADDR); end
    checks++; if (PWDATA !== 32'h0) begin errors++; $display("FAIL rst_pwdata got=%h exp=0", PWDATA); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store;
    PREADY = 4'b0001;
    start(1'b1, 32'h1000_0004, 32'h1234_5678);
    @(negedge clk); // cycle 1: SETUP
    checks++; if (PSEL !== 4'b0001) begin errors++; $display("FAIL st_psel_c1 got=%b exp=0001", PSEL); end
    checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL st_pen_c1 got=%b exp=0", PENABLE); end
    checks++; if (PADDR !== 32'h4) begin errors++; $display("FAIL st_paddr_c1 got=%h exp=4", PADDR); end
    checks++; if (PWRITE !== 1'b1) begin errors++; $display("FAIL st_pwrite_c1 got=%b exp=1", PWRITE); end
    checks++; if (PWDATA !== 32'h1234_5678) begin errors++; $display("FAIL st_pwdata_c1 got=%h exp=12345678", PWDATA); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL st_ready_c1 got=%b exp=0", ready); end
    @(negedge clk); // cycle 2: ACCESS
    checks++; if (PSEL !== 4'b0001) begin errors++; $display("FAIL st_psel_c2 got=%b exp=0001", PSEL); end
    checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL st_pen_c2 got=%b exp=1", PENABLE); end
    checks++; if (PWRITE !== 1'b1) begin errors++; $display("FAIL st_pwrite_c2 got=%b exp=1", PWRITE); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL st_ready_c2 got=%b exp=0", ready); end
    @(negedge clk); // cycle 3: completion
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL st_ready_c3 got=%b exp=1", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL st_err_c3 got=%b exp=0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL st_rdata_c3 got=%h exp=0", rdata); end
    checks++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0) begin errors++; $display("FAIL st_bus_idle_c3 got=%b/%b exp=0000/0", PSEL, PENABLE); end
    req = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL st_ready_c4 got=%b exp=0", ready); end
  endtask

  task automatic test_load_wait;
    PREADY = 4'b0001; // slave 0 ready must not complete a slave 1 access
    PRDATA = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h1111_1111};
    start(1'b0, 32'h1000_0110, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 5) begin
        checks++; if (PSEL !== 4'b0010) begin errors++; $display("FAIL ld_psel_c%0d got=%b exp=0010", k, PSEL); end
        checks++; if (PENABLE !== (k >= 2)) begin errors++; $display("FAIL ld_pen_c%0d got=%b exp=%b", k, PENABLE, (k >= 2)); end
        checks++; if (PADDR !== 32'h10) begin errors++; $display("FAIL ld_paddr_c%0d got=%h exp=10", k, PADDR); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ld_ready_c%0d got=%b exp=0", k, ready); end
        if (k == 5) PREADY[1] = 1'b1;
      end else begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ld_ready_c6 got=%b exp=1", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ld_err_c6 got=%b exp=0", err); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_rdata_c6 got=%h exp=deadbeef", rdata); end
        checks++; if (PSEL !== 4'b0000) begin errors++; $display("FAIL ld_psel_c6 got=%b exp=0000", PSEL); end
      end
    end
    req = 1'b0;
    PREADY = 4'b0001;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ld_ready_c7 got=%b exp=0", ready); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_rdata_hold got=%h exp=deadbeef", rdata); end
  endtask

  task automatic test_decode_err;
    start(1'b0, 32'h2000_0000, 32'h0);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL de_base_ready got=%b exp=1", ready); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL de_base_err got=%b exp=1", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL de_base_rdata got=%h exp=0", rdata); end
    checks++; if (PSEL !== 4'b0000) begin errors++; $display("FAIL de_base_psel got=%b exp=0000", PSEL); end
    req = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL de_hold got=%b/%b exp=0/1", ready, err); end
    start(1'b0, 32'h1000_0500, 32'h0);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL de_slot_ready got=%b exp=1", ready); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL de_slot_err got=%b exp=1", err); end
    checks++; if (PSEL !== 4'b0000) begin errors++; $display("FAIL de_slot_psel got=%b exp=0000", PSEL); end
    req = 1'b0;
    @(negedge clk);
    checks++; if (PSEL !== 4'b0000) begin errors++; $display("FAIL de_slot_psel2 got=%b exp=0000", PSEL); end
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    PREADY = 4'b1111;
    PRDATA = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
    start(1'b0, 32'h1000_0208, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
      if (k == 3) begin
        checks++; if (ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL b2b_first got=%b/%b exp=1/0", ready, err); end
        checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rdata got=%h exp=cafef00d", rdata); end
      end
      if (k == 4) begin
        checks++; if (PSEL !== 4'b0000) begin errors++; $display("FAIL b2b_no_dup_c4 got=%b exp=0000", PSEL); end
      end
      if (k == 5) begin
        checks++; if (PSEL !== 4'b0100 || PENABLE !== 1'b0) begin errors++; $display("FAIL b2b_setup_c5 got=%b/%b exp=0100/0", PSEL, PENABLE); end
      end
      if (k == 7) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_second got=%b exp=1", ready); end
        req = 1'b0;
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    PREADY = 4'b0000;
    start(1'b0, 32'h1000_0300, 32'h0);
    repeat (3) @(negedge clk);
    checks++; if (PSEL !== 4'b1000 || PENABLE !== 1'b1) begin errors++; $display("FAIL rm_access got=%b/%b exp=1000/1", PSEL, PENABLE); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (PSEL !== 4'b0000) begin errors++; $display("FAIL rm_psel_async got=%b exp=0000", PSEL); end
    checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL rm_pen_async got=%b exp=0", PENABLE); end
    @(negedge clk);
    reset_n = 1'b1;
    req = 1'b0;
    PREADY = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rm_no_ready got=%0d exp=0", pulses); end
    checks++; if (PSEL !== 4'b0000) begin errors++; $display("FAIL rm_idle_psel got=%b exp=0000", PSEL); end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    PREADY = 4'b0000;
    PRDATA = {32'h0, 32'h0, 32'h5A5A_5A5A, 32'h0};
    start(1'b0, 32'h1000_0100, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 5) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL to_ready_c%0d got=%b exp=0", k, ready); end
      end else begin
        checks++; if (ready !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL to_expire got=%b/%b exp=1/1", ready, err); end
        checks++; if (rdata !== 32'h0 || PSEL !== 4'b0000) begin errors++; $display("FAIL to_rdata_psel got=%h/%b exp=0/0000", rdata, PSEL); end
      end
    end
    req = 1'b0;
    @(negedge clk);
    start(1'b0, 32'h1000_0100, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) PREADY[1] = 1'b1;
      if (k == 6) begin
        checks++; if (ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL to_race got=%b/%b exp=1/0", ready, err); end
        checks++; if (rdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL to_race_rdata got=%h exp=5a5a5a5a", rdata); end
      end
    end
    req = 1'b0;
    PREADY = 4'b0000;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_store;
    test_load_wait;
    test_decode_err;
    test_back_to_back;
    test_reset_mid;
`ifdef APB_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
